load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the 64-word data memory; it drives the memory's mem_read/mem_write/address/write-data inputs and consumes its combinational read data.
- Adds byte/halfword/word loads (signed or unsigned) and stores on top of the word-only memory. Sub-word stores use a read-modify-write sequence.
- Checks alignment and returns one response per request.
- Holds busy while an access is in flight so the CPU stalls.

Parameters:
- IDX_BITS, 6, word-index width; mem_address = zero-extended req_addr[IDX_BITS+1:2]; byte-address bits above IDX_BITS+1 ignored (wrap).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request strobe, sampled only when busy=0
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte/half is used for sub-word stores
- busy  out  1  high while the unit is not IDLE
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned or illegal size
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_address  out  32  word index, zero-extended
- mem_write_data  out  32  to memory write_data
- mem_read_data  in  32  from memory read_data (combinational)

Behaviour:
- Byte order is little-endian. Byte lane n is selected by addr[1:0]=n and sits at bits [8n+7:8n]. A halfword at addr[1]=h sits at bits [16h+15:16h].
- States: IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, DONE. State and captured request fields are registered.
- All mem_* outputs decode from the registered state and request fields. No combinational path runs from req_* to mem_*.
- IDLE: busy=0. On req_valid=1 at a clock edge, capture addr/size/signed/write/wdata, then move to:
  - DONE with err=1 if size=11, or half with addr[0]=1, or word with addr[1:0]!=0. No memory access occurs.
  - LOAD for a legal load.
  - ST_WORD for a word store.
  - RMW_RD for a byte/half store.
- LOAD: mem_read=1. At the edge, extract and extend the addressed lane from mem_read_data into resp_rdata, then go to DONE.
- ST_WORD: mem_write=1, mem_write_data=wdata, then go to DONE.
- RMW_RD: mem_read=1. At the edge, capture the word, replace the addressed byte/half with the low bits of wdata, then go to RMW_WR.
- RMW_WR: mem_write=1, mem_write_data=merged word, then go to DONE.
- DONE: resp_valid=1 for exactly one cycle with resp_err/resp_rdata, then IDLE. A new request is accepted in IDLE on the cycle after DONE.
- Latency from the accept edge to resp_valid:
  - error: 1 cycle
  - load, word store: 2 cycles
  - sub-word store: 3 cycles
- mem_read and mem_write are never both 1.
- Outside LOAD/RMW_RD, mem_read=0. Outside ST_WORD/RMW_WR, mem_write=0.
- mem_address holds the captured index in every non-IDLE state. It is 0 in IDLE.
- mem_write_data is 0 when mem_write=0.
- req_valid while busy=1 is ignored: no queuing, no effect on the transaction in flight.
- resp_rdata and resp_err hold their last values after DONE until the next DONE. Stores and errors set resp_rdata=0.
- Reset values (immediate, asynchronous): state IDLE, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Reset mid-operation aborts the transaction: no response is issued and no further memory write occurs.

Test Plan:
- Memory reset (word17=56, word15=65); load word, addr 0x44 -> mem_read high 1 cycle with mem_address=17; resp_valid 2 cycles after accept; resp_rdata=0x00000038, resp_err=0; mem_write never high.
- Store byte 0xAB at addr 0x3D -> RMW_RD reads 0x00000041; one mem_write cycle with mem_address=15 and data 0x0000AB41. Then:
  - load byte signed at 0x3D -> 0xFFFFFFAB
  - load byte unsigned at 0x3D -> 0x000000AB
- Store half 0x8001 at 0x46 -> word17=0x80010038. Then:
  - load half signed at 0x46 -> 0xFFFF8001
  - load half unsigned at 0x46 -> 0x00008001
  - load word at 0x44 -> 0x80010038
- Load word at 0x45, half at 0x43, size=11 at 0x40 -> each gives resp_err=1 and resp_rdata=0, 1 cycle after accept; mem_read/mem_write stay 0.
- Word store 0x12345678 to 0x00 with req_valid held high and a different request applied while busy -> busy-cycle request ignored; next request accepted only in IDLE; word0=0x12345678.
- Assert rst during RMW_WR of a byte store -> mem_write drops at once; busy=0; no resp_valid; after release, the next load behaves normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-only memory, with read-modify-write for sub-word stores
module load_store_unit #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [2:0] {IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, DONE} state_t;
    state_t state, state_n;
    logic [IDX_BITS+1:0] addr_q;
    logic [31:0] wdata_q, merged_q, load_val, mask, merged_n;
    logic [1:0]  size_q;
    logic        signed_q, req_err;
    logic [4:0]  sh;
    logic [15:0] lane;
    logic        unused_addr;
    assign unused_addr = &{1'b0, req_addr[31:IDX_BITS+2]};
    assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    // lane shift works for halves too: a legal half always has addr[0]=0
    assign sh       = {addr_q[1:0], 3'b000};
    assign lane     = 16'(mem_read_data >> sh);
    assign load_val = size_q == 2'b00 ? {{24{signed_q & lane[7]}}, lane[7:0]} :
                      size_q == 2'b01 ? {{16{signed_q & lane[15]}}, lane} : mem_read_data;
    assign mask     = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged_n = (mem_read_data & ~mask) | ((wdata_q << sh) & mask);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n        = state;
        busy           = state != IDLE;
        resp_valid     = state == DONE;
        mem_read       = state == LOAD || state == RMW_RD;
        mem_write      = state == ST_WORD || state == RMW_WR;
        mem_address    = busy ? {{(32-IDX_BITS){1'b0}}, addr_q[IDX_BITS+1:2]} : 32'd0;
        mem_write_data = state == ST_WORD ? wdata_q : state == RMW_WR ? merged_q : 32'd0;
        case (state)
            IDLE:                  if (req_valid) state_n = req_err ? DONE : !req_write ? LOAD :
                                                            req_size == 2'b10 ? ST_WORD : RMW_RD;
            LOAD, ST_WORD, RMW_WR: state_n = DONE;
            RMW_RD:                state_n = RMW_WR;
            default:               state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            wdata_q    <= 32'd0;
            merged_q   <= 32'd0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr[IDX_BITS+1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
                if (req_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'd0;
                end
            end
            if (state == LOAD) begin
                resp_err   <= 1'b0;
                resp_rdata <= load_val;
            end
            if (state == RMW_RD) merged_q <= merged_n;
            if (state == ST_WORD || state == RMW_WR) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: checks load_store_unit cycle by cycle against a transaction-level model and a bench-owned memory
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        busy, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    always #5 clk = ~clk;
    load_store_unit #(.IDX_BITS(6)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        mem_init = 1'b0;
    always @(posedge clk)
        if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        else if (mem_write) mem[mem_address[5:0]] <= mem_write_data;
    assign mem_read_data = mem[mem_address[5:0]];
    int total = 0, bad = 0;
    logic        check_en = 1'b0;
    logic        e_busy, e_rv, e_rd, e_wr, e_err;
    logic [31:0] e_addr, e_wd, e_rdata;
    logic        m_err = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        seen_err;
    logic [31:0] seen_rdata;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk)
        if (check_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("resp_err", 32'(resp_err), 32'(e_err));
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            chk("mem_write", 32'(mem_write), 32'(e_wr));
            chk("mem_address", mem_address, e_addr);
            chk("mem_write_data", mem_write_data, e_wd);
            if (resp_valid) begin
                seen_rdata = resp_rdata;
                seen_err   = resp_err;
            end
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set(input logic b, input logic v, input logic r, input logic w,
                       input logic [31:0] ad, input logic [31:0] wd);
        e_busy = b; e_rv = v; e_rd = r; e_wr = w; e_addr = ad; e_wd = wd;
        e_err = m_err; e_rdata = m_rdata;
    endtask
    task automatic set_idle();
        set(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask
    task automatic drive_junk(input logic junk);
        req_valid = junk;
        if (junk) begin
            req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
        end
    endtask
    // one request from IDLE to the following IDLE cycle; expected behaviour derived from byte lanes
    task automatic txn(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic junk);
        logic [5:0]  idx;
        logic        er;
        logic [31:0] old, nw, ld;
        logic [7:0]  by [4];
        int          ln;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        seen_rdata = 'x; seen_err = 1'bx;
        idx = a[7:2]; ln = int'(a[1:0]);
        er  = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        old = ref_mem[idx];
        for (int k = 0; k < 4; k++) by[k] = old[8*k +: 8];
        ld = old; nw = wd;
        if (!er && sz == 2'b00) begin
            ld = sg ? {{24{by[ln][7]}}, by[ln]} : {24'd0, by[ln]};
            by[ln] = wd[7:0];
            nw = {by[3], by[2], by[1], by[0]};
        end else if (!er && sz == 2'b01) begin
            ld = sg ? {{16{by[ln+1][7]}}, by[ln+1], by[ln]} : {16'd0, by[ln+1], by[ln]};
            by[ln] = wd[7:0]; by[ln+1] = wd[15:8];
            nw = {by[3], by[2], by[1], by[0]};
        end
        tick();
        if (!er && (!w || sz != 2'b10)) begin
            set(1'b1, 1'b0, 1'b1, 1'b0, 32'(idx), 32'd0);
            drive_junk(junk);
            tick();
        end
        if (!er && w) begin
            set(1'b1, 1'b0, 1'b0, 1'b1, 32'(idx), nw);
            ref_mem[idx] = nw;
            drive_junk(junk);
            tick();
        end
        m_err = er;
        m_rdata = (er || w) ? 32'd0 : ld;
        set(1'b1, 1'b1, 1'b0, 1'b0, 32'(idx), 32'd0);
        drive_junk(junk);
        tick();
        req_valid = 1'b0;
        set_idle();
    endtask
    task automatic pin(input string nm, input logic [31:0] rd, input logic er);
        chk({nm, "_rdata"}, seen_rdata, rd);
        chk({nm, "_err"}, 32'(seen_err), 32'(er));
        chk({nm, "_model"}, m_rdata, rd);
    endtask
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[15] = 32'd65;
        ref_mem[17] = 32'd56;
        mem_init = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        tick();
        mem_init = 1'b0;
        set_idle();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        txn(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 1'b0);
        pin("lw44", 32'h0000_0038, 1'b0);
        txn(1'b1, 2'b00, 1'b0, 32'h3d, 32'h1234_56ab, 1'b0);
        chk("word15", mem[15], 32'h0000_ab41);
        txn(1'b0, 2'b00, 1'b1, 32'h3d, 32'd0, 1'b0);
        pin("lb3d", 32'hffff_ffab, 1'b0);
        txn(1'b0, 2'b00, 1'b0, 32'h3d, 32'd0, 1'b0);
        pin("lbu3d", 32'h0000_00ab, 1'b0);
        txn(1'b1, 2'b01, 1'b0, 32'h46, 32'hdead_8001, 1'b0);
        chk("word17", mem[17], 32'h8001_0038);
        txn(1'b0, 2'b01, 1'b1, 32'h46, 32'd0, 1'b0);
        pin("lh46", 32'hffff_8001, 1'b0);
        txn(1'b0, 2'b01, 1'b0, 32'h46, 32'd0, 1'b0);
        pin("lhu46", 32'h0000_8001, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 1'b0);
        pin("lw44b", 32'h8001_0038, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'h45, 32'd0, 1'b0);
        pin("lw45", 32'd0, 1'b1);
        txn(1'b0, 2'b01, 1'b1, 32'h43, 32'd0, 1'b0);
        pin("lh43", 32'd0, 1'b1);
        txn(1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 1'b0);
        pin("sz11", 32'd0, 1'b1);
        txn(1'b1, 2'b10, 1'b0, 32'h00, 32'h1234_5678, 1'b1);
        pin("sw00", 32'd0, 1'b0);
        chk("word0", mem[0], 32'h1234_5678);
        // byte store aborted by reset while its write cycle is on the bus
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h5a;
        tick();
        req_valid = 1'b0;
        set(1'b1, 1'b0, 1'b1, 1'b0, 32'd8, 32'd0);
        tick();
        rst = 1'b1;
        m_err = 1'b0;
        m_rdata = 32'd0;
        set_idle();
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        chk("abort_word8", mem[8], ref_mem[8]);
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b0);
        pin("after_abort", ref_mem[8], 1'b0);
        for (int n = 0; n < 300; n++)
            txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
